// File: rtl/alu_pkg.sv
// Shared definitions for the sequential divider slice.
//   DIV_WIDTH    default operand/result width
//   div_state_t  divider controller state encoding
//   cnt_width()  width of an iteration counter covering 0..w-1
package alu_pkg;

  localparam int DIV_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } div_state_t;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/addsub_n.sv
// N-bit adder/subtractor.
//   A, B   operands
//   sel    0: A + B, 1: A - B (B complemented, carry-in 1)
//   Sum    N-bit result
//   C_out  carry out; in subtract mode 1 means no borrow (A >= B)
module addsub_n #(
  parameter int N = 5
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         sel,
  output logic [N-1:0] Sum,
  output logic         C_out
);

  logic [N-1:0] b_eff;

  assign b_eff = B ^ {N{sel}};
  assign {C_out, Sum} = {1'b0, A} + {1'b0, b_eff} + {{N{1'b0}}, sel};

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequential restoring divider controller, one quotient bit per clock.
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      begin a division (accepted in IDLE only)
//   dividend   unsigned dividend, captured when start is accepted
//   divisor    unsigned divisor, captured when start is accepted
//   busy       high in LOAD, ITER and DONE
//   done       one-cycle pulse while results become valid
//   quotient   registered quotient (all ones on divide-by-zero)
//   remainder  registered remainder (dividend on divide-by-zero)
//   div_zero   registered divide-by-zero flag
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; results held
// LOAD   | clear partial remainder and counter, seed shift register
// ITER   | one restoring step per cycle, WIDTH cycles
// DONE   | done pulse; results were loaded on the edge entering DONE
module div_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_t state_q, state_d;

  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_q, rem_d;
  // Holds the unconsumed dividend bits in its upper part and collects
  // quotient bits from the bottom as they are produced.
  logic [WIDTH-1:0] qw_q, qw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] quo_d, rmd_d;
  logic             dz_d, done_d, busy_d;

  logic [WIDTH:0]   trial_a;
  logic [WIDTH:0]   diff;
  logic             no_borrow;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_q;

  // Shift in the next dividend bit. The partial remainder is always below
  // the divisor, so its top bit is zero and nothing is lost by the shift.
  assign trial_a = (rem_q << 1) | {{WIDTH{1'b0}}, qw_q[WIDTH-1]};

  addsub_n #(.N(WIDTH + 1)) u_addsub (
    .A     (trial_a),
    .B     ({1'b0, dvs_q}),
    .sel   (1'b1),
    .Sum   (diff),
    .C_out (no_borrow)
  );

  assign step_rem = no_borrow ? diff : trial_a;
  assign step_q   = {qw_q[WIDTH-2:0], no_borrow};

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    qw_d    = qw_q;
    cnt_d   = cnt_q;
    quo_d   = quotient;
    rmd_d   = remainder;
    dz_d    = div_zero;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        rem_d = '0;
        cnt_d = '0;
        qw_d  = dvd_q;
        if (dvs_q == '0) begin
          state_d = S_DONE;
          quo_d   = '1;
          rmd_d   = dvd_q;
          dz_d    = 1'b1;
          done_d  = 1'b1;
        end else begin
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        rem_d = step_rem;
        qw_d  = step_q;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          quo_d   = step_q;
          rmd_d   = step_rem[WIDTH-1:0];
          dz_d    = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      qw_q      <= '0;
      cnt_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      qw_q      <= qw_d;
      cnt_q     <= cnt_d;
      quotient  <= quo_d;
      remainder <= rmd_d;
      div_zero  <= dz_d;
      done      <= done_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl. Expected results are pushed when a
// division is started and popped when done is observed. Latency is counted
// in cycles from the cycle in which start is high (lat 0) to the cycle in
// which done is observed high.
module tb_div_seq_ctrl;
  import alu_pkg::*;

  localparam int W = DIV_WIDTH;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1; e.lat = 2;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0; e.lat = W + 2;
    end
    return e;
  endfunction

  // Drives one division, pushes its expectation, and reports what the DUT
  // did. inj > 0 pulses start with 5/5 in that cycle.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input int inj,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic dz, output int lat_done, output int ndone,
                        output logic busy_gap, output logic busy_after);
    int lat;
    q = '0; r = '0; dz = 1'b0; lat_done = -1; ndone = 0;
    busy_gap = 1'b0; busy_after = 1'b0;
    sb.push_back(model(a, b));
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    lat = 0;
    while (lat < 24 && (lat_done < 0 || lat < lat_done + 3)) begin
      @(negedge clk);
      lat++;
      if (done) begin
        ndone++;
        if (lat_done < 0) begin
          lat_done = lat; q = quotient; r = remainder; dz = div_zero;
        end
      end
      if (lat_done < 0 && !busy) busy_gap = 1'b1;
      if (lat_done >= 0 && lat > lat_done && busy) busy_after = 1'b1;
      if (lat == 1) start = 1'b0;
      if (inj > 0 && lat == inj) begin
        start = 1'b1; dividend = 4'd5; divisor = 4'd5;
      end
      if (inj > 0 && lat == inj + 1) start = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    n_assert++;
    if ({busy, done, quotient, remainder, div_zero} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d dz=%b required all 0",
               busy, done, quotient, remainder, div_zero);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_assert++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] av[3] = '{4'd13, 4'd15, 4'd2};
    logic [W-1:0] bv[3] = '{4'd3, 4'd1, 4'd9};
    logic [W-1:0] q, r; logic dz, bg, ba; int lat, nd; exp_t e;
    for (int i = 0; i < 3; i++) begin
      do_div(av[i], bv[i], 0, q, r, dz, lat, nd, bg, ba);
      e = sb.pop_front();
      n_assert += 4;
      if (q !== e.q) begin
        n_fail++; $display("FAIL basic_quotient %0d/%0d: got %0d required %0d", av[i], bv[i], q, e.q);
      end
      if (r !== e.r) begin
        n_fail++; $display("FAIL basic_remainder %0d/%0d: got %0d required %0d", av[i], bv[i], r, e.r);
      end
      if (dz !== e.dz) begin
        n_fail++; $display("FAIL basic_div_zero %0d/%0d: got %b required %b", av[i], bv[i], dz, e.dz);
      end
      if (lat != e.lat) begin
        n_fail++; $display("FAIL basic_latency %0d/%0d: got %0d required %0d", av[i], bv[i], lat, e.lat);
      end
    end
    // Results must hold while idle.
    repeat (4) @(negedge clk);
    n_assert++;
    if (quotient !== 4'd0 || remainder !== 4'd2 || div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_results: got q=%0d r=%0d dz=%b required 0 2 0", quotient, remainder, div_zero);
    end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] q, r; logic dz, bg, ba; int lat, nd; exp_t e;
    do_div(4'd7, 4'd0, 0, q, r, dz, lat, nd, bg, ba);
    e = sb.pop_front();
    n_assert += 4;
    if (q !== e.q) begin n_fail++; $display("FAIL dz_quotient: got %0d required %0d", q, e.q); end
    if (r !== e.r) begin n_fail++; $display("FAIL dz_remainder: got %0d required %0d", r, e.r); end
    if (dz !== e.dz) begin n_fail++; $display("FAIL dz_flag: got %b required %b", dz, e.dz); end
    if (lat != e.lat) begin n_fail++; $display("FAIL dz_latency: got %0d required %0d", lat, e.lat); end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] q, r; logic dz, bg, ba; int lat, nd; exp_t e;
    do_div(4'd13, 4'd3, 3, q, r, dz, lat, nd, bg, ba);
    e = sb.pop_front();
    n_assert += 6;
    if (q !== e.q || r !== e.r) begin
      n_fail++; $display("FAIL ignore_result: got %0d/%0d required %0d/%0d", q, r, e.q, e.r);
    end
    if (lat != e.lat) begin n_fail++; $display("FAIL ignore_latency: got %0d required %0d", lat, e.lat); end
    if (nd != 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d required 1", nd); end
    if (bg !== 1'b0) begin n_fail++; $display("FAIL ignore_busy_gap: got %b required 0", bg); end
    if (ba !== 1'b0) begin n_fail++; $display("FAIL ignore_busy_after: got %b required 0", ba); end
    if (dz !== e.dz) begin n_fail++; $display("FAIL ignore_div_zero: got %b required %b", dz, e.dz); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] q, r; logic dz, bg, ba; int lat, nd; exp_t e;
    // start pulsed in the done cycle must not launch another division
    do_div(4'd13, 4'd3, W + 2, q, r, dz, lat, nd, bg, ba);
    e = sb.pop_front();
    n_assert += 3;
    if (q !== e.q || r !== e.r) begin
      n_fail++; $display("FAIL b2b_first_result: got %0d/%0d required %0d/%0d", q, r, e.q, e.r);
    end
    if (nd != 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d required 1", nd); end
    if (ba !== 1'b0) begin n_fail++; $display("FAIL b2b_start_in_done: busy after done got %b required 0", ba); end
    do_div(4'd6, 4'd2, 0, q, r, dz, lat, nd, bg, ba);
    e = sb.pop_front();
    n_assert += 2;
    if (q !== e.q || r !== e.r) begin
      n_fail++; $display("FAIL b2b_second_result: got %0d/%0d required %0d/%0d", q, r, e.q, e.r);
    end
    if (lat != e.lat) begin n_fail++; $display("FAIL b2b_second_latency: got %0d required %0d", lat, e.lat); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] q, r; logic dz, bg, ba; int lat, nd, ndone; exp_t e;
    @(negedge clk);
    start = 1'b1; dividend = 4'd9; divisor = 4'd2;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    n_assert++;
    if ({busy, done, quotient, remainder, div_zero} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got busy=%b done=%b q=%0d r=%0d dz=%b required all 0",
               busy, done, quotient, remainder, div_zero);
    end
    rst = 1'b0; start = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) ndone++;
    end
    n_assert++;
    if (ndone != 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d pulses required 0", ndone); end
    do_div(4'd9, 4'd2, 0, q, r, dz, lat, nd, bg, ba);
    e = sb.pop_front();
    n_assert++;
    if (q !== e.q || r !== e.r || lat != e.lat) begin
      n_fail++; $display("FAIL midreset_rerun: got %0d/%0d lat %0d required %0d/%0d lat %0d",
                         q, r, lat, e.q, e.r, e.lat);
    end
  endtask

  task automatic test_sweep();
    logic [W-1:0] q, r; logic dz, bg, ba; int lat, nd; exp_t e;
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        do_div(W'(a), W'(b), 0, q, r, dz, lat, nd, bg, ba);
        e = sb.pop_front();
        n_assert++;
        if (q !== e.q || r !== e.r || dz !== e.dz || lat != e.lat) begin
          n_fail++;
          $display("FAIL sweep %0d/%0d: got q=%0d r=%0d dz=%b lat=%0d required q=%0d r=%0d dz=%b lat=%0d",
                   a, b, q, r, dz, lat, e.q, e.r, e.dz, e.lat);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d entries required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/div_seq_ctrl.md
DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand/result bit width.
REQ-002 SHALL have port: clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 SHALL have port: dividend  input  WIDTH  unsigned dividend; captured on accepted start.
REQ-006 SHALL have port: divisor  input  WIDTH  unsigned divisor; captured on accepted start.
REQ-007 SHALL have port: busy  output  1  high while a division is in progress (LOAD, ITER, DONE).
REQ-008 SHALL have port: done  output  1  one-cycle pulse when results become valid.
REQ-009 SHALL have port: quotient  output  WIDTH  registered unsigned quotient.
REQ-010 SHALL have port: remainder  output  WIDTH  registered unsigned remainder.
REQ-011 SHALL have port: div_zero  output  1  registered flag, divisor was zero.

Function
REQ-012 SHALL implement an FSM with states IDLE, LOAD, ITER, DONE.
REQ-013 SHALL accept start only in IDLE; start in any other state is ignored with no effect.
REQ-014 IDLE->LOAD on start; LOAD captures operands and clears the partial remainder (WIDTH+1 bits) and the iteration counter.
REQ-015 LOAD->DONE if captured divisor is zero, else LOAD->ITER.
REQ-016 ITER SHALL run exactly WIDTH cycles, each one restoring-division step: shift partial remainder left, inserting the next dividend bit (MSB first); trial-subtract divisor through the add/sub unit in subtract mode (operand complemented, carry-in 1).
REQ-017 Per step: carry-out 1 (no borrow) -> partial remainder takes the difference and the quotient bit is 1; carry-out 0 -> partial remainder is restored and the quotient bit is 0.
REQ-018 Iteration counter SHALL count 0..WIDTH-1; ITER->DONE when the counter reaches WIDTH-1, with no wrap-around into further steps.
REQ-019 DONE SHALL last one cycle, assert done, update quotient/remainder/div_zero, then go to IDLE.
REQ-020 Latency: start sampled at edge N -> done high during cycle N+WIDTH+2 (6 cycles for WIDTH=4); divide-by-zero -> done during cycle N+2.
REQ-021 On divide-by-zero: quotient SHALL be all ones, remainder SHALL equal dividend, div_zero=1; otherwise div_zero=0.
REQ-022 quotient, remainder and div_zero SHALL hold their values until the next DONE or reset.
REQ-023 A start asserted in the same cycle that done pulses is ignored; a new start is accepted from the following IDLE cycle.
REQ-024 Remainder output SHALL be the low WIDTH bits of the partial remainder; it is always < divisor when divisor != 0.

Reset
REQ-025 rst SHALL force state IDLE, busy=0, done=0, quotient=0, remainder=0, div_zero=0, counter=0 on the next clock edge.
REQ-026 rst asserted mid-operation SHALL abort the division with no done pulse; rst has priority over start.

Structure
REQ-027 State encoding and WIDTH default SHALL be defined in shared package alu_pkg.
REQ-028 The WIDTH+1-bit trial subtraction SHALL be one sub-module, addsub_n (inputs A, B, sel; outputs Sum, C_out), instantiated once with sel tied to 1.
REQ-029 All outputs SHALL be registered; no combinational path from start/operands to outputs.

Verification
REQ-030 13/3: start with dividend=13, divisor=3 -> done after 6 cycles, quotient=4, remainder=1, div_zero=0.
REQ-031 15/1 and 2/9 -> (quotient 15, remainder 0) and (quotient 0, remainder 2).
REQ-032 7/0 -> done 2 cycles after start, quotient=15, remainder=7, div_zero=1.
REQ-033 13/3 running, start with 5/5 pulsed during ITER -> ignored; results 4/1, busy continuous, exactly one done.
REQ-034 rst during ITER of 9/2 -> next cycle IDLE, all outputs 0, no done; subsequent 9/2 -> quotient 4, remainder 1.
REQ-035 Exhaustive sweep of all 256 operand pairs -> quotient/remainder match integer division; divisor 0 per REQ-021.
